// File: rtl/mul_pipe_m1m4_pkg.sv
// Shared constants, stage record and operand-sign helper for the M1..M4 multiplier pipeline.
package mul_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_IDX_W = 4;
  localparam int EXC_W     = 3;
  localparam int MUL_LAT   = 4;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam logic [EXC_W-1:0] EXC_NONE    = 3'b000;
  localparam logic [EXC_W-1:0] EXC_ILLEGAL = 3'b001;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [EXC_W-1:0]     exc;
    logic                 sel_hi;
  } stage_t;

  // Returns {sign_a, sign_b}: which operands are sign-extended to 33 bits.
  function automatic logic [1:0] ext_signs(input logic [2:0] funct3);
    logic [1:0] s;
    case (funct3)
      F3_MUL:    s = 2'b11;
      F3_MULH:   s = 2'b11;
      F3_MULHSU: s = 2'b10;
      F3_MULHU:  s = 2'b00;
      default:   s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mul_pipe_m1m4_if.sv
// Issue/writeback-facing bundle of the multiplier; slave = multiplier, master = surrounding pipeline.
interface mul_pipe_m1m4_if;
  import mul_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_a;
  logic [XLEN-1:0]      in_b;
  logic [2:0]           in_funct3;
  logic [ROB_IDX_W-1:0] in_rob_idx;
  logic [EXC_W-1:0]     in_exception_vector;
  logic                 in_stall;
  logic                 in_flush;
  logic [XLEN-1:0]      out_mul_out;
  logic [ROB_IDX_W-1:0] out_complete_idx;
  logic                 out_complete;
  logic [EXC_W-1:0]     out_exception_vector;
  logic                 out_busy;

  modport slave (
    input  in_valid, in_a, in_b, in_funct3, in_rob_idx, in_exception_vector, in_stall, in_flush,
    output in_ready, out_mul_out, out_complete_idx, out_complete, out_exception_vector, out_busy
  );

  modport master (
    output in_valid, in_a, in_b, in_funct3, in_rob_idx, in_exception_vector, in_stall, in_flush,
    input  in_ready, out_mul_out, out_complete_idx, out_complete, out_exception_vector, out_busy
  );

endinterface

// File: rtl/mul_pipe_m1m4_s33.sv
// 33x33 signed multiply split over two registered stages: M2 forms four 17x17 partial
// products, M3 sums them. Only the low 64 product bits are kept; the result never needs more.
module mul_s33_pipe (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic signed [32:0] a_i,
  input  logic signed [32:0] b_i,
  output logic [63:0]        prod_o
);

  logic signed [33:0] a_hi_s, a_lo_s, b_hi_s, b_lo_s;
  logic signed [33:0] pp_hh_q, pp_hh_d, pp_hl_q, pp_hl_d;
  logic signed [33:0] pp_lh_q, pp_lh_d, pp_ll_q, pp_ll_d;
  logic [63:0]        sum_s, prod_q, prod_d;

  // Operand split (signed high half, zero-extended low half), partial products and their sum.
  always_comb begin
    a_hi_s = {{17{a_i[32]}}, a_i[32:16]};
    a_lo_s = {18'd0, a_i[15:0]};
    b_hi_s = {{17{b_i[32]}}, b_i[32:16]};
    b_lo_s = {18'd0, b_i[15:0]};

    if (en) begin
      pp_hh_d = a_hi_s * b_hi_s;
      pp_hl_d = a_hi_s * b_lo_s;
      pp_lh_d = a_lo_s * b_hi_s;
      pp_ll_d = a_lo_s * b_lo_s;
    end else begin
      pp_hh_d = pp_hh_q;
      pp_hl_d = pp_hl_q;
      pp_lh_d = pp_lh_q;
      pp_ll_d = pp_ll_q;
    end

    sum_s = ({{30{pp_hh_q[33]}}, pp_hh_q} << 6'd32)
          + ({{30{pp_hl_q[33]}}, pp_hl_q} << 6'd16)
          + ({{30{pp_lh_q[33]}}, pp_lh_q} << 6'd16)
          +  {{30{pp_ll_q[33]}}, pp_ll_q};

    if (en) begin
      prod_d = sum_s;
    end else begin
      prod_d = prod_q;
    end
  end

  // M2 partial-product and M3 product registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pp_hh_q <= 34'sd0;
      pp_hl_q <= 34'sd0;
      pp_lh_q <= 34'sd0;
      pp_ll_q <= 34'sd0;
      prod_q  <= 64'd0;
    end else begin
      pp_hh_q <= pp_hh_d;
      pp_hl_q <= pp_hl_d;
      pp_lh_q <= pp_lh_d;
      pp_ll_q <= pp_ll_d;
      prod_q  <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/mul_pipe_m1m4.sv
// Four-stage RV32M multiplier (M1 operand latch, M2/M3 datapath, M4 result select) feeding M5/WB.
// Stage valids, ROB index and exception vector travel here; the arithmetic lives in mul_s33_pipe.
module mul_pipe_m1m4
  import mul_pkg::*;
(
  input logic             clk,
  input logic             reset,
  mul_pipe_m1m4_if.slave  io
);

  stage_t               m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
  logic signed [32:0]   a33_q, a33_d, b33_q, b33_d;
  logic [XLEN-1:0]      out_mul_out_q, out_mul_out_d;
  logic [ROB_IDX_W-1:0] out_idx_q, out_idx_d;
  logic [EXC_W-1:0]     out_exc_q, out_exc_d;
  logic                 out_complete_q, out_complete_d;
  logic                 out_busy_q, out_busy_d;
  logic                 advance_s, accept_s;
  logic [1:0]           signs_s;
  logic [63:0]          prod_s;

  // Stage advance/hold/flush control and M1 capture, M4 result select.
  always_comb begin
    advance_s      = ~io.in_stall;
    accept_s       = io.in_valid & advance_s & ~io.in_flush;
    signs_s        = ext_signs(io.in_funct3);
    m1_d           = m1_q;
    m2_d           = m2_q;
    m3_d           = m3_q;
    a33_d          = a33_q;
    b33_d          = b33_q;
    out_mul_out_d  = out_mul_out_q;
    out_idx_d      = out_idx_q;
    out_exc_d      = out_exc_q;
    out_complete_d = out_complete_q;

    if (io.in_flush) begin
      m1_d.valid     = 1'b0;
      m2_d.valid     = 1'b0;
      m3_d.valid     = 1'b0;
      out_complete_d = 1'b0;
      out_mul_out_d  = '0;
      out_idx_d      = '0;
      out_exc_d      = EXC_NONE;
    end else if (advance_s) begin
      m1_d.valid   = accept_s;
      m1_d.rob_idx = io.in_rob_idx;
      m1_d.sel_hi  = (io.in_funct3 != F3_MUL);
      // An exception raised upstream takes precedence over our own illegal-funct3 report.
      if (io.in_exception_vector != EXC_NONE) begin
        m1_d.exc = io.in_exception_vector;
      end else if (io.in_funct3[2]) begin
        m1_d.exc = EXC_ILLEGAL;
      end else begin
        m1_d.exc = EXC_NONE;
      end
      a33_d = {signs_s[1] & io.in_a[XLEN-1], io.in_a};
      b33_d = {signs_s[0] & io.in_b[XLEN-1], io.in_b};
      m2_d  = m1_q;
      m3_d  = m2_q;

      out_complete_d = m3_q.valid;
      if (m3_q.valid) begin
        out_idx_d = m3_q.rob_idx;
        out_exc_d = m3_q.exc;
        if (m3_q.exc != EXC_NONE) begin
          out_mul_out_d = '0;
        end else if (m3_q.sel_hi) begin
          out_mul_out_d = prod_s[63:32];
        end else begin
          out_mul_out_d = prod_s[31:0];
        end
      end else begin
        out_idx_d     = '0;
        out_exc_d     = EXC_NONE;
        out_mul_out_d = '0;
      end
    end else begin
      out_complete_d = out_complete_q;
    end

    out_busy_d = m1_d.valid | m2_d.valid | m3_d.valid | out_complete_d;
  end

  // Stage records, M1 operands and M4 output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m1_q           <= '0;
      m2_q           <= '0;
      m3_q           <= '0;
      a33_q          <= 33'sd0;
      b33_q          <= 33'sd0;
      out_mul_out_q  <= '0;
      out_idx_q      <= '0;
      out_exc_q      <= EXC_NONE;
      out_complete_q <= 1'b0;
      out_busy_q     <= 1'b0;
    end else begin
      m1_q           <= m1_d;
      m2_q           <= m2_d;
      m3_q           <= m3_d;
      a33_q          <= a33_d;
      b33_q          <= b33_d;
      out_mul_out_q  <= out_mul_out_d;
      out_idx_q      <= out_idx_d;
      out_exc_q      <= out_exc_d;
      out_complete_q <= out_complete_d;
      out_busy_q     <= out_busy_d;
    end
  end

  mul_s33_pipe u_s33 (
    .clk    (clk),
    .reset  (reset),
    .en     (advance_s),
    .a_i    (a33_q),
    .b_i    (b33_q),
    .prod_o (prod_s)
  );

  assign io.in_ready             = ~io.in_stall;
  assign io.out_mul_out          = out_mul_out_q;
  assign io.out_complete_idx     = out_idx_q;
  assign io.out_complete         = out_complete_q;
  assign io.out_exception_vector = out_exc_q;
  assign io.out_busy             = out_busy_q;

endmodule

// File: tb/tb_mul_pipe_m1m4.sv
// Directed self-checking bench for mul_pipe_m1m4: arithmetic, throughput, stall, flush,
// exception/illegal handling and asynchronous reset.
module tb_mul_pipe_m1m4;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mul_pipe_m1m4_if bus ();

  mul_pipe_m1m4 dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] idx, input logic [2:0] exc);
    bus.in_valid            = 1'b1;
    bus.in_funct3           = f3;
    bus.in_a                = a;
    bus.in_b                = b;
    bus.in_rob_idx          = idx;
    bus.in_exception_vector = exc;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (bus.out_complete !== 1'b0) begin
      failures++; $display("FAIL reset_complete: got %0b expected 0", bus.out_complete);
    end
    checks++;
    if ({bus.out_mul_out, bus.out_complete_idx, bus.out_exception_vector} !== 39'd0) begin
      failures++; $display("FAIL reset_data: got %h/%0d/%b expected 0/0/000",
                           bus.out_mul_out, bus.out_complete_idx, bus.out_exception_vector);
    end
    checks++;
    if (bus.out_busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %0b expected 0", bus.out_busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %0b expected 1", bus.in_ready);
    end
    step();
  endtask

  task automatic test_arith();
    logic [2:0]  f3  [6] = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU, F3_MUL, F3_MULHU};
    logic [31:0] va  [6] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h80000000};
    logic [31:0] vb  [6] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000010, 32'd2};
    logic [31:0] exp [6] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h23456780, 32'd1};
    for (int i = 0; i < 6; i++) begin
      drive_op(f3[i], va[i], vb[i], 4'(i + 1), 3'b000);
      step();
      bus.in_valid = 1'b0;
      for (int k = 0; k < MUL_LAT - 1; k++) step();
      checks++;
      if (bus.out_complete !== 1'b1 || bus.out_complete_idx !== 4'(i + 1)) begin
        failures++; $display("FAIL arith_complete[%0d]: got c=%0b idx=%0d expected c=1 idx=%0d",
                             i, bus.out_complete, bus.out_complete_idx, i + 1);
      end
      checks++;
      if (bus.out_mul_out !== exp[i]) begin
        failures++; $display("FAIL arith_result[%0d]: got %h expected %h", i, bus.out_mul_out, exp[i]);
      end
      checks++;
      if (bus.out_exception_vector !== 3'b000) begin
        failures++; $display("FAIL arith_exc[%0d]: got %b expected 000", i, bus.out_exception_vector);
      end
      step();
      checks++;
      if (bus.out_complete !== 1'b0) begin
        failures++; $display("FAIL arith_one_cycle[%0d]: got %0b expected 0", i, bus.out_complete);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4] = '{32'd100, 32'd200, 32'd300, 32'd400};
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive_op(F3_MUL, 32'(c + 1), 32'd100, 4'(c + 1), 3'b000);
      else bus.in_valid = 1'b0;
      step();
      if (c >= 3 && c <= 6) begin
        checks++;
        if (bus.out_complete !== 1'b1 || bus.out_complete_idx !== 4'(c - 2) || bus.out_mul_out !== exp[c-3]) begin
          failures++; $display("FAIL b2b_order[%0d]: got c=%0b idx=%0d r=%0d expected c=1 idx=%0d r=%0d",
                               c, bus.out_complete, bus.out_complete_idx, bus.out_mul_out, c - 2, exp[c-3]);
        end
      end
      if (c == 6) begin
        checks++;
        if (bus.out_busy !== 1'b1) begin
          failures++; $display("FAIL b2b_busy_last: got %0b expected 1", bus.out_busy);
        end
      end
      if (c == 7) begin
        checks++;
        if (bus.out_complete !== 1'b0 || bus.out_busy !== 1'b0) begin
          failures++; $display("FAIL b2b_drain: got c=%0b busy=%0b expected 0/0", bus.out_complete, bus.out_busy);
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 3; c++) begin
      drive_op(F3_MUL, 32'(c + 1), 32'd11, 4'(c + 5), 3'b000);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    bus.in_stall = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL stall_ready: got %0b expected 0", bus.in_ready);
    end
    for (int s = 0; s < 5; s++) begin
      step();
      checks++;
      if (bus.out_complete !== 1'b1 || bus.out_complete_idx !== 4'd5 || bus.out_mul_out !== 32'd11) begin
        failures++; $display("FAIL stall_frozen[%0d]: got c=%0b idx=%0d r=%0d expected c=1 idx=5 r=11",
                             s, bus.out_complete, bus.out_complete_idx, bus.out_mul_out);
      end
    end
    bus.in_stall = 1'b0;
    step();
    checks++;
    if (bus.out_complete !== 1'b1 || bus.out_complete_idx !== 4'd6 || bus.out_mul_out !== 32'd22) begin
      failures++; $display("FAIL stall_release2: got c=%0b idx=%0d r=%0d expected c=1 idx=6 r=22",
                           bus.out_complete, bus.out_complete_idx, bus.out_mul_out);
    end
    step();
    checks++;
    if (bus.out_complete !== 1'b1 || bus.out_complete_idx !== 4'd7 || bus.out_mul_out !== 32'd33) begin
      failures++; $display("FAIL stall_release3: got c=%0b idx=%0d r=%0d expected c=1 idx=7 r=33",
                           bus.out_complete, bus.out_complete_idx, bus.out_mul_out);
    end
    step();
    checks++;
    if (bus.out_complete !== 1'b0) begin
      failures++; $display("FAIL stall_drain: got %0b expected 0", bus.out_complete);
    end
  endtask

  task automatic test_flush();
    logic seen;
    for (int c = 0; c < 4; c++) begin
      drive_op(F3_MUL, 32'd2, 32'd2, 4'(c + 1), 3'b000);
      step();
    end
    // Output stage is occupied but stalled, so nothing has transferred when the flush hits.
    drive_op(F3_MUL, 32'd3, 32'd3, 4'd9, 3'b000);
    bus.in_stall = 1'b1;
    bus.in_flush = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_stall = 1'b0;
    bus.in_flush = 1'b0;
    checks++;
    if (bus.out_complete !== 1'b0 || bus.out_busy !== 1'b0) begin
      failures++; $display("FAIL flush_clear: got c=%0b busy=%0b expected 0/0", bus.out_complete, bus.out_busy);
    end
    seen = 1'b0;
    for (int s = 0; s < 6; s++) begin
      step();
      seen = seen | bus.out_complete | bus.out_busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL flush_no_completion: got activity=%0b expected 0", seen);
    end
  endtask

  task automatic test_exception();
    drive_op(F3_MUL, 32'd5, 32'd6, 4'd7, 3'b100);
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < MUL_LAT - 1; k++) step();
    checks++;
    if (bus.out_complete !== 1'b1 || bus.out_complete_idx !== 4'd7 || bus.out_exception_vector !== 3'b100) begin
      failures++; $display("FAIL exc_pass: got c=%0b idx=%0d exc=%b expected c=1 idx=7 exc=100",
                           bus.out_complete, bus.out_complete_idx, bus.out_exception_vector);
    end
    checks++;
    if (bus.out_mul_out !== 32'd0) begin
      failures++; $display("FAIL exc_result: got %h expected 0", bus.out_mul_out);
    end
    step();
    drive_op(3'b101, 32'd3, 32'd4, 4'd2, 3'b000);
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < MUL_LAT - 1; k++) step();
    checks++;
    if (bus.out_complete !== 1'b1 || bus.out_complete_idx !== 4'd2 || bus.out_exception_vector !== EXC_ILLEGAL) begin
      failures++; $display("FAIL illegal_exc: got c=%0b idx=%0d exc=%b expected c=1 idx=2 exc=001",
                           bus.out_complete, bus.out_complete_idx, bus.out_exception_vector);
    end
    checks++;
    if (bus.out_mul_out !== 32'd0) begin
      failures++; $display("FAIL illegal_result: got %h expected 0", bus.out_mul_out);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic seen;
    drive_op(F3_MUL, 32'd9, 32'd9, 4'd3, 3'b000);
    step();
    drive_op(F3_MUL, 32'd2, 32'd3, 4'd4, 3'b000);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    checks++;
    if (bus.out_complete !== 1'b1 || bus.out_mul_out !== 32'd81) begin
      failures++; $display("FAIL rstmid_pre: got c=%0b r=%0d expected c=1 r=81", bus.out_complete, bus.out_mul_out);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_complete !== 1'b0 || bus.out_busy !== 1'b0 ||
        {bus.out_mul_out, bus.out_complete_idx, bus.out_exception_vector} !== 39'd0) begin
      failures++; $display("FAIL rstmid_immediate: got c=%0b busy=%0b r=%h idx=%0d expected all 0",
                           bus.out_complete, bus.out_busy, bus.out_mul_out, bus.out_complete_idx);
    end
    step();
    reset = 1'b1;
    seen = 1'b0;
    for (int s = 0; s < 6; s++) begin
      step();
      seen = seen | bus.out_complete;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL rstmid_no_completion: got %0b expected 0", seen);
    end
  endtask

  initial begin
    bus.in_valid            = 1'b0;
    bus.in_a                = 32'd0;
    bus.in_b                = 32'd0;
    bus.in_funct3           = 3'b000;
    bus.in_rob_idx          = 4'd0;
    bus.in_exception_vector = 3'b000;
    bus.in_stall            = 1'b0;
    bus.in_flush            = 1'b0;
    test_reset();
    test_arith();
    test_back_to_back();
    test_stall();
    test_flush();
    test_exception();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
